// File: rtl/uart_parameters.sv
// System-wide UART timing constants shared by the transmit and receive paths.
package uart_parameters;
    localparam int CLOCK_FREQ = 1_600_000;
    localparam int BAUD_RATE  = 100_000;
endpackage

// File: rtl/uart_rx_pkg.sv
// Receive-path types and bit timing derived from the shared UART clock/baud settings.
package uart_rx_pkg;
    import uart_parameters::*;

    localparam int BAUD_LIMIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_LIMIT = BAUD_LIMIT / 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received word plus status strobes out.
interface uart_rx_if #(parameter int WORD_SIZE = 8);
    logic                 rx;
    logic [WORD_SIZE-1:0] data_recv;
    logic                 rx_valid_o;
    logic                 rx_frame_err_o;
    logic                 rx_busy_o;

    modport master (output rx, input data_recv, rx_valid_o, rx_frame_err_o, rx_busy_o);
    modport slave  (input rx, output data_recv, rx_valid_o, rx_frame_err_o, rx_busy_o);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start/data(MSB first)/stop framing, mid-bit sampling, valid and framing-error strobes.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the sample point.
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int              BCW      = $clog2(WORD_SIZE);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WORD_SIZE - 1);
    localparam logic [15:0]     BAUD_END = 16'(BAUD_LIMIT - 1);

    logic rx_s;
    logic bit_s;

    uart_rx_sync u_sync (.clk(clk), .rst(rst), .d_i(bus.rx), .q_o(rx_s));

`ifdef UART_RX_MAJORITY_EN
    // Vote window is the two preceding rx_s values plus the current one, so
    // the start decision lands one clock later; later bits keep that offset.
    localparam logic [15:0] START_END = 16'(HALF_LIMIT);
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= {hist_q[0], rx_s};
    end

    assign bit_s = maj3(hist_q[1], hist_q[0], rx_s);
`else
    localparam logic [15:0] START_END = 16'(HALF_LIMIT - 1);
    assign bit_s = rx_s;
`endif

    rx_state_e            state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (baud_q == START_END) begin
                    baud_d = '0;
                    if (!bit_s) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_END) begin
                    baud_d  = '0;
                    shift_d = {shift_q[WORD_SIZE-2:0], bit_s};
                    if (bit_q == LAST_BIT) state_d = ST_STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_END) begin
                    baud_d = '0;
                    if (bit_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Only one error per low stretch: stay here until the line recovers.
                baud_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.data_recv      = data_q;
    assign bus.rx_valid_o     = valid_q;
    assign bus.rx_frame_err_o = ferr_q;
    assign bus.rx_busy_o      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame table plus glitch, break, mid-frame reset and spike sequences.
module tb_uart_receiver;
    import uart_rx_pkg::*;

    localparam int W = 8;
    localparam int T = BAUD_LIMIT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_if #(.WORD_SIZE(W)) bus ();
    uart_receiver #(.WORD_SIZE(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [W-1:0] sb_q[$];
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        logic         stop;
        int           gap;
        logic [W-1:0] exp_recv;
        int           exp_errs;
        logic         exp_busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
            prev_e = 1'b0;
        end else begin
            if (bus.rx_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=%0h expected=none", bus.data_recv);
                end else begin
                    chk("sb_data", 32'(bus.data_recv), 32'(sb_q.pop_front()));
                end
                chk("valid_not_repeated", 32'(prev_v), 32'd0);
            end
            if (bus.rx_frame_err_o) begin
                err_cnt++;
                chk("err_excl_valid", 32'(bus.rx_valid_o), 32'd0);
                chk("err_not_repeated", 32'(prev_e), 32'd0);
            end
            prev_v = bus.rx_valid_o;
            prev_e = bus.rx_frame_err_o;
        end
    end

    task automatic send_bit(input logic b, input int spike);
        for (int c = 0; c < T; c++) begin
            bus.rx = (c == spike) ? 1'b0 : b;
            @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, -1);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int spike_bit,
                              input logic [W-1:0] exp, input logic push);
        if (push) sb_q.push_back(exp);
        send_bit(1'b0, -1);
        for (int i = 0; i < W; i++) send_bit(d[W-1-i], (i == spike_bit) ? HALF_LIMIT : -1);
        send_bit(stop, -1);
    endtask

    vec_t vecs[7];
    logic [W-1:0] spike_exp;

    initial begin
        bus.rx = 1'b1;
        vecs[0] = '{8'hA5, 1'b1, 2, 8'hA5, 0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1, 8'h3C, 0, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 0, 8'hC3, 0, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1, 8'hC3, 1, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 1, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 0, 8'h00, 1, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 2, 8'hFF, 1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_data_recv", 32'(bus.data_recv), 32'd0);
        chk("rst_valid", 32'(bus.rx_valid_o), 32'd0);
        chk("rst_frame_err", 32'(bus.rx_frame_err_o), 32'd0);
        chk("rst_busy", 32'(bus.rx_busy_o), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Frame table; gap 0 means the start bit follows the previous stop bit directly.
        foreach (vecs[i]) begin
            idle_bits(vecs[i].gap);
            send_frame(vecs[i].data, vecs[i].stop, -1, vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d_data_recv", i), 32'(bus.data_recv), 32'(vecs[i].exp_recv));
            chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_errs));
            chk($sformatf("vec%0d_busy", i), 32'(bus.rx_busy_o), 32'(vecs[i].exp_busy));
        end
        idle_bits(2);
        chk("table_sb_empty", 32'(sb_q.size()), 32'd0);

        // Short low glitch on an idle line: start rejected, nothing reported.
        bus.rx = 1'b0;
        repeat (T / 4) @(negedge clk);
        chk("glitch_busy_in_start", 32'(bus.rx_busy_o), 32'd1);
        bus.rx = 1'b1;
        repeat (T) @(negedge clk);
        chk("glitch_busy_after", 32'(bus.rx_busy_o), 32'd0);
        chk("glitch_data_recv", 32'(bus.data_recv), 32'hFF);
        chk("glitch_err_cnt", 32'(err_cnt), 32'd1);

        // Bad stop bit followed by a held-low line: one error, then a good frame.
        send_frame(8'h55, 1'b0, -1, 8'h00, 1'b0);
        bus.rx = 1'b0;
        repeat (3 * T) @(negedge clk);
        chk("break_busy", 32'(bus.rx_busy_o), 32'd1);
        chk("break_err_cnt", 32'(err_cnt), 32'd2);
        chk("break_data_recv", 32'(bus.data_recv), 32'hFF);
        bus.rx = 1'b1;
        repeat (T) @(negedge clk);
        chk("break_recovered", 32'(bus.rx_busy_o), 32'd0);
        send_frame(8'h81, 1'b1, -1, 8'h81, 1'b1);
        chk("after_break_data", 32'(bus.data_recv), 32'h81);

        // Reset during bit 4 of 8'hFF aborts the frame silently.
        idle_bits(1);
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
        bus.rx = 1'b1;
        repeat (T / 2) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.rx_busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_data_recv", 32'(bus.data_recv), 32'd0);
        chk("midrst_busy", 32'(bus.rx_busy_o), 32'd0);
        chk("midrst_valid", 32'(bus.rx_valid_o), 32'd0);
        chk("midrst_frame_err", 32'(bus.rx_frame_err_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_bits(2);
        send_frame(8'h12, 1'b1, -1, 8'h12, 1'b1);
        chk("post_reset_data", 32'(bus.data_recv), 32'h12);

        // One-clock low spike at the mid point of data bit 3 of 8'hFF.
`ifdef UART_RX_MAJORITY_EN
        spike_exp = 8'hFF;
`else
        spike_exp = 8'hEF;
`endif
        idle_bits(1);
        send_frame(8'hFF, 1'b1, 3, spike_exp, 1'b1);
        chk("spike_data", 32'(bus.data_recv), 32'(spike_exp));

        idle_bits(1);
        for (int i = 0; i < 4 * T && sb_q.size() != 0; i++) @(negedge clk);
        chk("final_sb_drain", 32'(sb_q.size()), 32'd0);
        chk("final_err_cnt", 32'(err_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
